bit_slice: RTL and testbench

- One bit of a bit-sliced serial shift/subtract divider datapath. N identical slices abut; carries and shift bits ripple between neighbours.
- Each slice holds four state bits:
  - DIVL: dividend / low word.
  - DIVH: divisor / high word.
  - ACC: partial remainder.
  - RESULT: quotient.
- Each slice also contains four conditional two's-complement negator cells (OP1, OP2, remainder, result) and one full-adder cell for trial subtraction.
- A scan chain is threaded through all flops for test.

---
 rtl/cond_negator.sv | 17 +
 rtl/bit_slice.sv | 103 ++++++++++
 tb/tb_bit_slice.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_negator.sv
// Conditional two's-complement negator cell: invert the bit on request and
// ripple the +1 carry upward through the neighbouring slices.
module cond_negator (
    input  logic in,
    input  logic inv,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic x;

    assign x    = in ^ inv;
    assign sum  = x ^ cin;
    assign cout = x & cin;

endmodule

// File: rtl/bit_slice.sv
// One bit of the bit-sliced serial shift/subtract divider: DIVL/DIVH/ACC/RESULT
// state, four conditional negators, trial-subtract full adder, scan chain.
module bit_slice (
    input  logic Clock,
    input  logic nReset,
    input  logic Operand1,
    input  logic Operand2,
    input  logic INV_OP1,
    input  logic INV_OP2,
    input  logic OP1_INV_Cin,
    input  logic OP2_INV_Cin,
    output logic OP1_INV_Cout,
    output logic OP2_INV_Cout,
    input  logic LOAD_DIVL,
    input  logic LOAD_DIVH,
    input  logic DIVL_P,
    input  logic DIVH_P,
    output logic DIVL_1,
    output logic DIVH_1,
    output logic DIVH_0,
    input  logic DIVH_0_P,
    input  logic ACC_Cin,
    output logic ACC_Cout,
    input  logic LOAD_ACC,
    input  logic STORE_ACC,
    input  logic INV_REM,
    input  logic ACC_INV_Cin,
    output logic ACC_INV_Cout,
    input  logic STORE_REM,
    output logic Remainder,
    input  logic RESULT_P,
    input  logic RESULT_nP_0,
    output logic RESULT_1,
    input  logic INV_RESULT,
    input  logic RESULT_INV_Cin,
    output logic RESULT_INV_Cout,
    input  logic STORE_QUOT,
    output logic Quotient,
    input  logic Test,
    input  logic SDI
);

    logic divl_q, divh_q, acc_q, result_q;
    logic op1_sum, op2_sum, rem_sum, res_sum;
    logic add_sum;

    cond_negator u_op1_neg (
        .in(Operand1), .inv(INV_OP1), .cin(OP1_INV_Cin),
        .sum(op1_sum), .cout(OP1_INV_Cout)
    );

    cond_negator u_op2_neg (
        .in(Operand2), .inv(INV_OP2), .cin(OP2_INV_Cin),
        .sum(op2_sum), .cout(OP2_INV_Cout)
    );

    cond_negator u_rem_neg (
        .in(acc_q), .inv(INV_REM), .cin(ACC_INV_Cin),
        .sum(rem_sum), .cout(ACC_INV_Cout)
    );

    cond_negator u_res_neg (
        .in(result_q), .inv(INV_RESULT), .cin(RESULT_INV_Cin),
        .sum(res_sum), .cout(RESULT_INV_Cout)
    );

    // Trial subtraction: B input is the already-complemented divisor bit.
    assign add_sum  = acc_q ^ DIVH_0_P ^ ACC_Cin;
    assign ACC_Cout = (acc_q & DIVH_0_P) | (acc_q & ACC_Cin) | (DIVH_0_P & ACC_Cin);

    // Scan order: SDI -> DIVL -> DIVH -> ACC -> RESULT.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            divl_q   <= 1'b0;
            divh_q   <= 1'b0;
            acc_q    <= 1'b0;
            result_q <= 1'b0;
        end else begin
            if (Test)           divl_q <= SDI;
            else if (LOAD_DIVL) divl_q <= op1_sum;
            else                divl_q <= DIVL_P;

            if (Test)           divh_q <= divl_q;
            else if (LOAD_DIVH) divh_q <= op2_sum;
            else                divh_q <= DIVH_P;

            if (Test)           acc_q <= divh_q;
            else if (LOAD_ACC)  acc_q <= add_sum;
            else if (STORE_ACC) acc_q <= divh_q;

            if (Test)              result_q <= acc_q;
            else if (!RESULT_nP_0) result_q <= RESULT_P;
        end
    end

    assign DIVL_1    = divl_q;
    assign DIVH_1    = divh_q;
    assign DIVH_0    = ~divh_q;
    assign RESULT_1  = result_q;
    assign Remainder = STORE_REM  ? rem_sum : 1'b0;
    assign Quotient  = STORE_QUOT ? res_sum : 1'b0;

endmodule

// File: tb/tb_bit_slice.sv
// Scoreboard bench for bit_slice: directed cases from the test plan, then
// randomized cycles checked against a behavioural model of the slice.
module tb_bit_slice;

    logic Clock = 1'b0;
    logic nReset;
    logic Operand1, Operand2, INV_OP1, INV_OP2, OP1_INV_Cin, OP2_INV_Cin;
    logic LOAD_DIVL, LOAD_DIVH, DIVL_P, DIVH_P, DIVH_0_P, ACC_Cin;
    logic LOAD_ACC, STORE_ACC, INV_REM, ACC_INV_Cin, STORE_REM;
    logic RESULT_P, RESULT_nP_0, INV_RESULT, RESULT_INV_Cin, STORE_QUOT;
    logic Test, SDI;
    logic OP1_INV_Cout, OP2_INV_Cout, DIVL_1, DIVH_1, DIVH_0, ACC_Cout;
    logic ACC_INV_Cout, Remainder, RESULT_1, RESULT_INV_Cout, Quotient;

    always #5 Clock = ~Clock;

    bit_slice dut (
        .Clock(Clock), .nReset(nReset),
        .Operand1(Operand1), .Operand2(Operand2),
        .INV_OP1(INV_OP1), .INV_OP2(INV_OP2),
        .OP1_INV_Cin(OP1_INV_Cin), .OP2_INV_Cin(OP2_INV_Cin),
        .OP1_INV_Cout(OP1_INV_Cout), .OP2_INV_Cout(OP2_INV_Cout),
        .LOAD_DIVL(LOAD_DIVL), .LOAD_DIVH(LOAD_DIVH),
        .DIVL_P(DIVL_P), .DIVH_P(DIVH_P),
        .DIVL_1(DIVL_1), .DIVH_1(DIVH_1), .DIVH_0(DIVH_0), .DIVH_0_P(DIVH_0_P),
        .ACC_Cin(ACC_Cin), .ACC_Cout(ACC_Cout),
        .LOAD_ACC(LOAD_ACC), .STORE_ACC(STORE_ACC),
        .INV_REM(INV_REM), .ACC_INV_Cin(ACC_INV_Cin), .ACC_INV_Cout(ACC_INV_Cout),
        .STORE_REM(STORE_REM), .Remainder(Remainder),
        .RESULT_P(RESULT_P), .RESULT_nP_0(RESULT_nP_0), .RESULT_1(RESULT_1),
        .INV_RESULT(INV_RESULT), .RESULT_INV_Cin(RESULT_INV_Cin),
        .RESULT_INV_Cout(RESULT_INV_Cout),
        .STORE_QUOT(STORE_QUOT), .Quotient(Quotient),
        .Test(Test), .SDI(SDI)
    );

    localparam int O_DIVL = 0, O_DIVH = 1, O_DIVH0 = 2, O_RES = 3, O_ACO = 4,
                   O_REM = 5, O_QUOT = 6, O_C1 = 7, O_C2 = 8, O_CREM = 9, O_CRES = 10;
    localparam int NOBS = 11;

    logic [NOBS-1:0] obs;
    assign obs = {RESULT_INV_Cout, ACC_INV_Cout, OP2_INV_Cout, OP1_INV_Cout, Quotient,
                  Remainder, ACC_Cout, RESULT_1, DIVH_0, DIVH_1, DIVL_1};

    string obs_name [NOBS] = '{"divl_1", "divh_1", "divh_0", "result_1", "acc_cout",
                               "remainder", "quotient", "op1_cout", "op2_cout",
                               "acc_inv_cout", "res_inv_cout"};

    typedef struct {
        string tag;
        int    idx;
        logic  val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int idx, input logic val);
        exp_t e;
        e.tag = tag; e.idx = idx; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, obs[e.idx], e.val);
        end
    endtask

    // Let combinational outputs settle, then check pending expectations.
    task automatic settle();
        #1;
        drain();
    endtask

    // One rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
        drain();
    endtask

    task automatic zero_inputs();
        {Operand1, Operand2, INV_OP1, INV_OP2, OP1_INV_Cin, OP2_INV_Cin} = '0;
        {LOAD_DIVL, LOAD_DIVH, DIVL_P, DIVH_P, DIVH_0_P, ACC_Cin} = '0;
        {LOAD_ACC, STORE_ACC, INV_REM, ACC_INV_Cin, STORE_REM} = '0;
        {RESULT_P, RESULT_nP_0, INV_RESULT, RESULT_INV_Cin, STORE_QUOT} = '0;
        {Test, SDI} = '0;
    endtask

    // Behavioural model state
    logic m_dl, m_dh, m_acc, m_res;

    function automatic logic [NOBS-1:0] model_obs(input logic dl, dh, acc, res);
        logic [NOBS-1:0] o;
        logic x1, x2, xr, xq;
        x1 = Operand1 ^ INV_OP1;
        x2 = Operand2 ^ INV_OP2;
        xr = acc ^ INV_REM;
        xq = res ^ INV_RESULT;
        o = '0;
        o[O_DIVL]  = dl;
        o[O_DIVH]  = dh;
        o[O_DIVH0] = !dh;
        o[O_RES]   = res;
        o[O_ACO]   = (acc + DIVH_0_P + ACC_Cin) >= 2;
        o[O_REM]   = STORE_REM && (xr != ACC_INV_Cin);
        o[O_QUOT]  = STORE_QUOT && (xq != RESULT_INV_Cin);
        o[O_C1]    = x1 && OP1_INV_Cin;
        o[O_C2]    = x2 && OP2_INV_Cin;
        o[O_CREM]  = xr && ACC_INV_Cin;
        o[O_CRES]  = xq && RESULT_INV_Cin;
        return o;
    endfunction

    task automatic model_step();
        logic n_dl, n_dh, n_acc, n_res;
        int s;
        if (Test) begin
            n_dl = SDI; n_dh = m_dl; n_acc = m_dh; n_res = m_acc;
        end else begin
            n_dl  = LOAD_DIVL ? ((Operand1 ^ INV_OP1) ^ OP1_INV_Cin) : DIVL_P;
            n_dh  = LOAD_DIVH ? ((Operand2 ^ INV_OP2) ^ OP2_INV_Cin) : DIVH_P;
            s     = int'(m_acc) + int'(DIVH_0_P) + int'(ACC_Cin);
            n_acc = LOAD_ACC ? s[0] : (STORE_ACC ? m_dh : m_acc);
            n_res = RESULT_nP_0 ? m_res : RESULT_P;
        end
        m_dl = n_dl; m_dh = n_dh; m_acc = n_acc; m_res = n_res;
    endtask

    initial begin
        logic [NOBS-1:0] mo;
        logic [3:0] scan_pat;
        zero_inputs();
        nReset = 1'b0;

        // Reset state, no clock edge involved
        #2;
        push("rst_divh_1", O_DIVH, 1'b0);
        push("rst_divh_0", O_DIVH0, 1'b1);
        push("rst_result_1", O_RES, 1'b0);
        push("rst_divl_1", O_DIVL, 1'b0);
        settle();
        @(negedge Clock);
        nReset = 1'b1;

        // DIVH shift
        DIVH_P = 1'b1;
        push("shift_divh_1", O_DIVH, 1'b1);
        push("shift_divh_0", O_DIVH0, 1'b0);
        tick();

        // DIVH load / negation with Operand2 = 0
        DIVH_P = 1'b0; LOAD_DIVH = 1'b1;
        push("load_divh_1", O_DIVH, 1'b0);
        push("load_divh_0", O_DIVH0, 1'b1);
        tick();
        INV_OP2 = 1'b1;
        push("inv_divh_1", O_DIVH, 1'b1);
        push("inv_divh_0", O_DIVH0, 1'b0);
        tick();
        OP2_INV_Cin = 1'b1;
        push("neg_divh_1", O_DIVH, 1'b0);
        push("neg_divh_0", O_DIVH0, 1'b1);
        push("neg_op2_cout", O_C2, 1'b1);
        tick();

        // Get DIVH = 1, then copy it into ACC with STORE_ACC
        OP2_INV_Cin = 1'b0;
        push("divh_set", O_DIVH, 1'b1);
        tick();
        LOAD_DIVH = 1'b0; INV_OP2 = 1'b0; STORE_ACC = 1'b1; STORE_REM = 1'b1;
        push("store_acc_rem", O_REM, 1'b1);
        push("store_acc_divh", O_DIVH, 1'b0);
        tick();

        // Adder: 1+1+1 -> sum 1 carry 1; LOAD_ACC must beat STORE_ACC (DIVH = 0)
        DIVH_0_P = 1'b1; ACC_Cin = 1'b1; LOAD_ACC = 1'b1;
        push("adder_cout_pre", O_ACO, 1'b1);
        settle();
        push("adder_acc_rem", O_REM, 1'b1);
        push("adder_cout_post", O_ACO, 1'b1);
        tick();
        DIVH_0_P = 1'b0; ACC_Cin = 1'b0;
        push("adder_sum0_cout", O_ACO, 1'b0);
        push("adder_sum0_rem", O_REM, 1'b1);
        tick();
        LOAD_ACC = 1'b0; STORE_ACC = 1'b0;

        // RESULT gets 1 then holds; quotient output gating
        RESULT_P = 1'b1;
        push("result_shift", O_RES, 1'b1);
        tick();
        RESULT_P = 1'b0; RESULT_nP_0 = 1'b1;
        push("result_hold", O_RES, 1'b1);
        push("quot_gated", O_QUOT, 1'b0);
        tick();
        STORE_QUOT = 1'b1;
        push("quot_on", O_QUOT, 1'b1);
        settle();
        INV_RESULT = 1'b1; RESULT_INV_Cin = 1'b1;
        push("quot_neg", O_QUOT, 1'b1);
        push("quot_neg_cout", O_CRES, 1'b0);
        settle();
        INV_RESULT = 1'b0; RESULT_INV_Cin = 1'b0; STORE_QUOT = 1'b0;

        // Scan shift 1,0,1,1
        @(negedge Clock);
        Test = 1'b1;
        scan_pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            SDI = scan_pat[i];
            push($sformatf("scan_divl_%0d", i), O_DIVL, scan_pat[i]);
            tick();
        end
        Test = 1'b0; SDI = 1'b0;
        push("scan_result_1", O_RES, 1'b1);
        push("scan_divl", O_DIVL, 1'b1);
        push("scan_divh", O_DIVH, 1'b1);
        push("scan_acc", O_REM, 1'b0);
        settle();

        // Mid-cycle reset with nonzero state
        Test = 1'b1; SDI = 1'b1;
        tick(); tick(); tick(); tick();
        Test = 1'b0;
        @(negedge Clock);
        #2;
        INV_REM = 1'b1;
        nReset = 1'b0;
        push("mrst_divl", O_DIVL, 1'b0);
        push("mrst_divh", O_DIVH, 1'b0);
        push("mrst_divh_0", O_DIVH0, 1'b1);
        push("mrst_result", O_RES, 1'b0);
        push("mrst_rem", O_REM, 1'b1);
        settle();
        @(negedge Clock);
        nReset = 1'b1;
        m_dl = 1'b0; m_dh = 1'b0; m_acc = 1'b0; m_res = 1'b0;

        // Randomized cycles against the model
        for (int c = 0; c < 300; c++) begin
            {Operand1, Operand2, INV_OP1, INV_OP2, OP1_INV_Cin, OP2_INV_Cin} = 6'($urandom);
            {LOAD_DIVL, LOAD_DIVH, DIVL_P, DIVH_P, DIVH_0_P, ACC_Cin} = 6'($urandom);
            {LOAD_ACC, STORE_ACC, INV_REM, ACC_INV_Cin, STORE_REM} = 5'($urandom);
            {RESULT_P, RESULT_nP_0, INV_RESULT, RESULT_INV_Cin, STORE_QUOT} = 5'($urandom);
            Test = ($urandom_range(0, 7) == 0);
            SDI  = 1'($urandom);
            mo = model_obs(m_dl, m_dh, m_acc, m_res);
            for (int k = 0; k < NOBS; k++) push({"pre_", obs_name[k]}, k, mo[k]);
            settle();
            model_step();
            mo = model_obs(m_dl, m_dh, m_acc, m_res);
            for (int k = 0; k < NOBS; k++) push({"post_", obs_name[k]}, k, mo[k]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
